// File: rtl/core_pkg.sv
// Shared core definitions: ALU opcode encoding, RV32 decode fields and the
// issue-stage payload handed from issue to execute.
package core_pkg;

  typedef enum logic [4:0] {
    ALU_NOP   = 5'd0,
    ALU_ADD   = 5'd1,
    ALU_SUB   = 5'd2,
    ALU_XOR   = 5'd3,
    ALU_OR    = 5'd4,
    ALU_AND   = 5'd5,
    ALU_SHL   = 5'd6,
    ALU_SHR   = 5'd7,
    ALU_SHLU  = 5'd8,
    ALU_SHRU  = 5'd9,
    ALU_SLT   = 5'd10,
    ALU_SGT   = 5'd11,
    ALU_AUI   = 5'd12,
    ALU_AUIPC = 5'd13,
    ALU_MUL   = 5'd14,
    ALU_DIV   = 5'd15,
    ALU_REM   = 5'd16
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_MUL  = 3'b000;
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_REM  = 3'b110;

  typedef struct packed {
    alu_op_t     alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } issue_payload_t;

endpackage

// File: rtl/alu_skid_buffer.sv
// Two-entry valid/ready skid buffer with flush; in_ready comes straight from a flop
// and the head entry drives the outputs directly.
module alu_skid_buffer #(
  parameter type T = logic [31:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t r_state;
  state_t w_state_nxt;
  T       r_head;
  T       r_skid;
  logic   r_in_ready;
  logic   w_accept;
  logic   w_issue;
  logic   w_load_head_in;
  logic   w_load_head_skid;
  logic   w_load_skid;

  assign w_accept  = in_valid && r_in_ready && !flush;
  assign w_issue   = (r_state != EMPTY) && out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != FULL);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = ONE;
          w_load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_issue) begin
          w_load_head_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = FULL;
          w_load_skid = 1'b1;
        end else if (w_issue) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        // Older entry leaves; the skid entry becomes the head so order is kept.
        if (w_issue) begin
          w_state_nxt      = ONE;
          w_load_head_skid = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    if (flush) w_state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
    end else if (w_load_head_in) begin
      r_head <= in_data;
    end else if (w_load_head_skid) begin
      r_head <= r_skid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_skid) r_skid <= in_data;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32I/M ALU instructions with writeback bypass at accept
// and queues the resulting payload through a skid buffer toward execute.
module alu_issue_stage
  import core_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_in,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [XLEN-1:0] pc,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);

  function automatic logic [XLEN-1:0] operand(input logic [4:0] addr, input logic [XLEN-1:0] rf,
                                              input logic en, input logic [4:0] wrd,
                                              input logic [XLEN-1:0] wdat);
    if (addr == 5'd0) return '0;
    if (BYPASS_EN && en && (wrd == addr)) return wdat;
    return rf;
  endfunction

  function automatic issue_payload_t decode(input logic [31:0] w, input logic [XLEN-1:0] pc_cur,
                                            input logic [XLEN-1:0] a_in,
                                            input logic [XLEN-1:0] b_in);
    issue_payload_t p;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       bad;
    f7      = w[31:25];
    f3      = w[14:12];
    bad     = 1'b0;
    p       = '0;
    p.pc    = pc_cur + 32'd4;
    p.rd    = w[11:7];
    case (w[6:0])
      OPC_OP: begin
        p.alu_a = a_in;
        p.alu_b = (f3 == F3_SLL || f3 == F3_SR) ? {27'b0, b_in[4:0]} : b_in;
        case (f7)
          F7_BASE: begin
            case (f3)
              F3_ADD:  p.alu_op = ALU_ADD;
              F3_SLL:  p.alu_op = ALU_SHL;
              F3_SLT:  p.alu_op = ALU_SLT;
              F3_SLTU: p.alu_op = ALU_SGT;
              F3_XOR:  p.alu_op = ALU_XOR;
              F3_SR:   p.alu_op = ALU_SHR;
              F3_OR:   p.alu_op = ALU_OR;
              default: p.alu_op = ALU_AND;
            endcase
          end
          F7_ALT: begin
            if (f3 == F3_ADD)     p.alu_op = ALU_SUB;
            else if (f3 == F3_SR) p.alu_op = ALU_SHRU;
            else                  bad = 1'b1;
          end
          F7_MULDIV: begin
            if (f3 == F3_MUL)      p.alu_op = ALU_MUL;
            else if (f3 == F3_DIV) p.alu_op = ALU_DIV;
            else if (f3 == F3_REM) p.alu_op = ALU_REM;
            else                   bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        p.alu_a = a_in;
        p.alu_b = {{20{w[31]}}, w[31:20]};
        case (f3)
          F3_ADD:  p.alu_op = ALU_ADD;
          F3_SLT:  p.alu_op = ALU_SLT;
          F3_SLTU: p.alu_op = ALU_SGT;
          F3_XOR:  p.alu_op = ALU_XOR;
          F3_OR:   p.alu_op = ALU_OR;
          F3_AND:  p.alu_op = ALU_AND;
          F3_SLL: begin
            p.alu_b = {27'b0, w[24:20]};
            if (f7 == F7_BASE) p.alu_op = ALU_SHL;
            else               bad = 1'b1;
          end
          default: begin
            p.alu_b = {27'b0, w[24:20]};
            if (f7 == F7_BASE)     p.alu_op = ALU_SHR;
            else if (f7 == F7_ALT) p.alu_op = ALU_SHRU;
            else                   bad = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        p.alu_op = ALU_AUI;
        p.alu_b  = {12'b0, w[31:12]};
      end
      OPC_AUIPC: begin
        p.alu_op = ALU_AUIPC;
        p.alu_a  = pc_cur;
        p.alu_b  = {12'b0, w[31:12]};
      end
      default: bad = 1'b1;
    endcase
    // Undecodable words still travel in order so execute can raise the trap.
    if (bad) begin
      p.alu_op = ALU_NOP;
      p.alu_a  = '0;
      p.alu_b  = '0;
    end
    p.illegal = bad;
    p.rd_we   = !bad && (p.rd != 5'd0);
    return p;
  endfunction

  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  issue_payload_t  w_in_payload;
  issue_payload_t  w_out_payload;

  assign rs1_addr     = instr[19:15];
  assign rs2_addr     = instr[24:20];
  assign w_rs1_val    = operand(rs1_addr, rs1_data, wb_en, wb_rd, wb_data);
  assign w_rs2_val    = operand(rs2_addr, rs2_data, wb_en, wb_rd, wb_data);
  assign w_in_payload = decode(instr, pc_in, w_rs1_val, w_rs2_val);

  alu_skid_buffer #(.T(issue_payload_t)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_payload)
  );

  assign alu_op  = w_out_payload.alu_op;
  assign alu_a   = w_out_payload.alu_a;
  assign alu_b   = w_out_payload.alu_b;
  assign pc      = w_out_payload.pc;
  assign rd      = w_out_payload.rd;
  assign rd_we   = w_out_payload.rd_we;
  assign illegal = w_out_payload.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: queue-based reference model checked every cycle,
// plus directed vectors with literal expected values.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'h0;
  logic [31:0] pc_in = 32'h0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data = 32'h0;
  logic [31:0] rs2_data = 32'h0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b, pc;
  logic [4:0]  rd;
  logic        rd_we, illegal;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .pc_in(pc_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .pc(pc), .rd(rd), .rd_we(rd_we), .illegal(illegal)
  );

  typedef struct {
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pcv;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t q[$];
  logic m_rdy = 1'b0;
  int   n_issue = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rdi, input logic [6:0] opc);
    return {f7, r2, r1, f3, rdi, opc};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rdi, input logic [6:0] opc);
    return {imm, r1, f3, rdi, opc};
  endfunction

  // Reference: what execute must receive for one accepted instruction.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pcv, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic wen, input logic [4:0] wrd,
                                 input logic [31:0] wdat);
    exp_t e;
    logic [31:0] x1, x2, simm;
    logic [4:0]  r1, r2;
    int op;
    r1 = ins[19:15];
    r2 = ins[24:20];
    x1 = (r1 == 0) ? 32'h0 : ((wen && wrd == r1) ? wdat : d1);
    x2 = (r2 == 0) ? 32'h0 : ((wen && wrd == r2) ? wdat : d2);
    simm = {{20{ins[31]}}, ins[31:20]};
    e.pcv = pcv + 32'd4;
    e.rd = ins[11:7];
    e.a = 32'h0;
    e.b = 32'h0;
    op = -1;
    case (ins[6:0])
      7'h33: begin
        case ({ins[31:25], ins[14:12]})
          10'h000: op = 1;  10'h001: op = 6;  10'h002: op = 10; 10'h003: op = 11;
          10'h004: op = 3;  10'h005: op = 7;  10'h006: op = 4;  10'h007: op = 5;
          10'h100: op = 2;  10'h105: op = 9;
          10'h008: op = 14; 10'h00C: op = 15; 10'h00E: op = 16;
          default: op = -1;
        endcase
        e.a = x1;
        e.b = (op == 6 || op == 7 || op == 9) ? {27'b0, x2[4:0]} : x2;
      end
      7'h13: begin
        e.a = x1;
        e.b = simm;
        case (ins[14:12])
          3'd0: op = 1;  3'd2: op = 10; 3'd3: op = 11;
          3'd4: op = 3;  3'd6: op = 4;  3'd7: op = 5;
          3'd1: op = (ins[31:25] == 7'h00) ? 6 : -1;
          default: op = (ins[31:25] == 7'h00) ? 7 : ((ins[31:25] == 7'h20) ? 9 : -1);
        endcase
        if (ins[13:12] == 2'b01) e.b = {27'b0, ins[24:20]};
      end
      7'h37: begin op = 12; e.b = {12'b0, ins[31:12]}; end
      7'h17: begin op = 13; e.a = pcv; e.b = {12'b0, ins[31:12]}; end
      default: op = -1;
    endcase
    if (op < 0) begin
      e.op = 0; e.a = 32'h0; e.b = 32'h0; e.we = 1'b0; e.ill = 1'b1;
    end else begin
      e.op = op; e.we = (e.rd != 0); e.ill = 1'b0;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_rdy = 1'b0;
    end else if (flush) begin
      q.delete();
      m_rdy = 1'b1;
    end else begin
      logic acc;
      acc = in_valid && m_rdy;
      if (q.size() != 0 && out_ready) begin
        void'(q.pop_front());
        n_issue++;
      end
      if (acc) q.push_back(model(instr, pc_in, rs1_data, rs2_data, wb_en, wb_rd, wb_data));
      m_rdy = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
      chk("out_valid", {31'b0, out_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
      if (q.size() != 0) begin
        chk("alu_op", {27'b0, alu_op}, q[0].op);
        chk("alu_a", alu_a, q[0].a);
        chk("alu_b", alu_b, q[0].b);
        chk("pc", pc, q[0].pcv);
        chk("rd", {27'b0, rd}, {27'b0, q[0].rd});
        chk("rd_we", {31'b0, rd_we}, {31'b0, q[0].we});
        chk("illegal", {31'b0, illegal}, {31'b0, q[0].ill});
      end
    end
  end

  // Offer one instruction at a negedge and hold it until the edge that accepts it.
  task automatic send(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] d1,
                      input logic [31:0] d2);
    instr = ins; pc_in = p; rs1_data = d1; rs2_data = d2; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  logic [31:0] vec [12];
  int base;

  initial begin
    vec[0]  = rtype(7'h01, 5'd2, 5'd1, 3'd0, 5'd9,  7'h33);
    vec[1]  = rtype(7'h01, 5'd2, 5'd1, 3'd4, 5'd10, 7'h33);
    vec[2]  = rtype(7'h01, 5'd2, 5'd1, 3'd6, 5'd11, 7'h33);
    vec[3]  = rtype(7'h20, 5'd2, 5'd1, 3'd5, 5'd12, 7'h33);
    vec[4]  = rtype(7'h00, 5'd2, 5'd1, 3'd1, 5'd13, 7'h33);
    vec[5]  = rtype(7'h00, 5'd2, 5'd1, 3'd3, 5'd14, 7'h33);
    vec[6]  = itype({7'h20, 5'd7}, 5'd1, 3'd5, 5'd15, 7'h13);
    vec[7]  = itype(12'h800, 5'd1, 3'd3, 5'd16, 7'h13);
    vec[8]  = itype(12'h005, 5'd1, 3'd0, 5'd0,  7'h13);
    vec[9]  = itype(12'h0F0, 5'd1, 3'd7, 5'd17, 7'h13);
    vec[10] = rtype(7'h00, 5'd2, 5'd1, 3'd5, 5'd18, 7'h33);
    vec[11] = rtype(7'h10, 5'd2, 5'd1, 3'd0, 5'd19, 7'h33);

    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_alu_op", {27'b0, alu_op}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_rd", {27'b0, rd}, 32'd0);
    chk("rst_rd_we", {31'b0, rd_we}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

    out_ready = 1'b1;
    instr = 32'hFFF08293;
    #1;
    chk("rs1_addr", {27'b0, rs1_addr}, 32'd1);
    chk("rs2_addr", {27'b0, rs2_addr}, 32'd31);
    send(32'hFFF08293, 32'h0, 32'h10, 32'h0);
    chk("addi_op", {27'b0, alu_op}, 32'd1);
    chk("addi_a", alu_a, 32'h10);
    chk("addi_b", alu_b, 32'hFFFFFFFF);
    chk("addi_rd", {27'b0, rd}, 32'd5);
    chk("addi_we", {31'b0, rd_we}, 32'd1);
    send(32'h123451B7, 32'h0, 32'h0, 32'h0);
    chk("lui_op", {27'b0, alu_op}, 32'd12);
    chk("lui_a", alu_a, 32'h0);
    chk("lui_b", alu_b, 32'h00012345);
    send(32'h00001097, 32'h100, 32'h0, 32'h0);
    chk("auipc_op", {27'b0, alu_op}, 32'd13);
    chk("auipc_pc", pc, 32'h104);
    chk("auipc_b", alu_b, 32'h1);
    @(negedge clk);

    out_ready = 1'b0;
    base = n_issue;
    send(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd6, 7'h33), 32'h200, 32'h1, 32'h2);
    send(rtype(7'h20, 5'd4, 5'd3, 3'd0, 5'd7, 7'h33), 32'h204, 32'h3, 32'h4);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_head_op", {27'b0, alu_op}, 32'd1);
    instr = rtype(7'h00, 5'd6, 5'd5, 3'd4, 5'd8, 7'h33);
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_still_full", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    send(rtype(7'h00, 5'd6, 5'd5, 3'd4, 5'd8, 7'h33), 32'h208, 32'h5, 32'h6);
    repeat (3) @(negedge clk);
    chk("bp_issued", n_issue - base, 32'd3);

    out_ready = 1'b0;
    base = n_issue;
    send(rtype(7'h00, 5'd2, 5'd1, 3'd7, 5'd20, 7'h33), 32'h300, 32'h1, 32'h2);
    send(rtype(7'h00, 5'd2, 5'd1, 3'd6, 5'd21, 7'h33), 32'h304, 32'h1, 32'h2);
    instr = rtype(7'h00, 5'd2, 5'd1, 3'd4, 5'd22, 7'h33);
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("flush_no_issue", n_issue - base, 32'd0);

    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD;
    send(rtype(7'h00, 5'd0, 5'd1, 3'd0, 5'd2, 7'h33), 32'h400, 32'h0, 32'h55);
    chk("byp_a", alu_a, 32'hDEAD);
    chk("byp_b_x0", alu_b, 32'h0);
    wb_rd = 5'd0;
    send(rtype(7'h00, 5'd0, 5'd1, 3'd0, 5'd2, 7'h33), 32'h404, 32'h77, 32'h55);
    chk("nobyp_a", alu_a, 32'h77);
    wb_rd = 5'd2;
    send(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h408, 32'h11, 32'h22);
    chk("byp_rs2_a", alu_a, 32'h11);
    chk("byp_rs2_b", alu_b, 32'hDEAD);
    wb_en = 1'b0;

    send(32'h0000007F, 32'h500, 32'h1, 32'h2);
    chk("ill_flag", {31'b0, illegal}, 32'd1);
    chk("ill_op", {27'b0, alu_op}, 32'd0);
    chk("ill_we", {31'b0, rd_we}, 32'd0);
    send(itype({7'h20, 5'd3}, 5'd1, 3'd1, 5'd4, 7'h13), 32'h504, 32'h1, 32'h2);
    chk("slli_f7_ill", {31'b0, illegal}, 32'd1);
    chk("slli_f7_op", {27'b0, alu_op}, 32'd0);
    chk("slli_f7_we", {31'b0, rd_we}, 32'd0);
    send(rtype(7'h01, 5'd2, 5'd1, 3'd3, 5'd5, 7'h33), 32'h508, 32'h1, 32'h2);
    chk("mulhu_ill", {31'b0, illegal}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      out_ready = (i % 3) != 1;
      send(vec[i], 32'h600 + 32'(i * 4), 32'h8000_0000 + 32'(i), 32'hFFFF_FFE0 + 32'(i));
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    out_ready = 1'b0;
    send(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd6, 7'h33), 32'h700, 32'h1, 32'h2);
    send(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33), 32'h704, 32'h1, 32'h2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("midrst_alu_op", {27'b0, alu_op}, 32'd0);
    chk("midrst_alu_a", alu_a, 32'd0);
    chk("midrst_pc", pc, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready_after", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
